eth_forward_pkt_buffer: RTL and testbench

// - Store-and-forward packet buffer ahead of the uplink port's forward input.
// - Accepts forwarded 10G Ethernet frames on AXIS and keeps only complete, error-free frames.
// - Raises o_forward_pkt_valid only once a whole frame is held, so the uplink port can hand it
//   the TX path without underrun.

---
 rtl/eth_forward_pkt_buffer_pkg.sv | 22 ++
 rtl/eth_forward_pkt_buffer_fwd_sdp_ram.sv | 25 ++
 rtl/eth_forward_pkt_buffer.sv | 188 ++++++++++++++++++
 tb/tb_eth_forward_pkt_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_forward_pkt_buffer_pkg.sv
// Shared definitions for the uplink forward store-and-forward buffer.
// The buffer stores one 73-bit word per AXIS beat: {tlast, tkeep, tdata}.
package eth_forward_pkt_buffer_pkg;

  localparam int unsigned AXIS_DATA_W = 64;
  localparam int unsigned AXIS_KEEP_W = 8;
  localparam int unsigned RAM_W       = AXIS_DATA_W + AXIS_KEEP_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } fwd_state_e;

  typedef struct packed {
    logic                   last;
    logic [AXIS_KEEP_W-1:0] keep;
    logic [AXIS_DATA_W-1:0] data;
  } fwd_word_t;

endpackage

// File: rtl/eth_forward_pkt_buffer_fwd_sdp_ram.sv
// Simple dual-port RAM: one clock, one write port, one read port with a
// registered output (1-cycle read latency). Written to infer block RAM.
module fwd_sdp_ram
  import eth_forward_pkt_buffer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = RAM_W
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_forward_pkt_buffer.sv
// Store-and-forward buffer ahead of the uplink forward input: only complete,
// error-free frames are released, and each is presented without underrun.
module eth_forward_pkt_buffer
  import eth_forward_pkt_buffer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                   i_data_clk,
  input  logic                   i_data_rst,
  input  logic                   s_axis_tvalid,
  input  logic [63:0]            s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic [7:0]             s_axis_tkeep,
  input  logic                   s_axis_tuser,
  output logic                   s_axis_tready,
  output logic                   o_forward_pkt_valid,
  output logic                   m_forward_axis_tvalid,
  output logic [63:0]            m_forward_axis_tdata,
  output logic                   m_forward_axis_tlast,
  output logic [7:0]             m_forward_axis_tkeep,
  output logic                   m_forward_axis_tuser,
  input  logic                   m_forward_axis_tready,
  output logic [CNT_WIDTH-1:0]   o_drop_cnt,
  output logic [CNT_WIDTH-1:0]   o_pkt_cnt
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr, head_ptr, used;
  logic [PTR_W-1:0] frames_stored;
  logic             drop_flag, full, wr_en, bad_end, commit;
  logic             rd_en, rd_pend, skid_v, pop, send_done;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]       occ;
  fwd_word_t        wr_word, rd_word, skid;
  fwd_state_e       state;

  assign s_axis_tready        = 1'b1;
  assign m_forward_axis_tuser = 1'b0;

  assign used    = wr_ptr - rd_ptr;
  assign full    = (used == DEPTH);
  assign wr_en   = s_axis_tvalid && !drop_flag && !full;
  assign bad_end = s_axis_tuser || drop_flag || full;
  assign commit  = s_axis_tvalid && s_axis_tlast && !bad_end;
  assign wr_word = '{last: s_axis_tlast,
                     keep: s_axis_tlast ? s_axis_tkeep : '1,
                     data: s_axis_tdata};

  fwd_sdp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(RAM_W)) u_ram (
    .clk     (i_data_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  always_ff @(posedge i_data_clk or posedge i_data_rst) begin
    if (i_data_rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_flag  <= 1'b0;
      o_drop_cnt <= '0;
    end else if (s_axis_tvalid) begin
      if (s_axis_tlast) begin
        if (bad_end) begin
          wr_ptr    <= commit_ptr;
          drop_flag <= 1'b0;
          if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
        end else begin
          wr_ptr     <= wr_ptr + 1'b1;
          commit_ptr <= wr_ptr + 1'b1;
        end
      end else if (full) begin
        drop_flag <= 1'b1;
      end else if (!drop_flag) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_data_clk or posedge i_data_rst) begin
    if (i_data_rst) begin
      frames_stored <= '0;
    end else begin
      case ({commit, send_done})
        2'b10:   frames_stored <= frames_stored + 1'b1;
        2'b01:   frames_stored <= frames_stored - 1'b1;
        default: frames_stored <= frames_stored;
      endcase
    end
  end

  // occ counts output register, skid entry and the read in flight after this
  // cycle's pop; a new read is issued only when a slot will be free for it.
  assign pop       = m_forward_axis_tvalid && m_forward_axis_tready;
  assign send_done = (state == ST_SEND) && pop && m_forward_axis_tlast;
  assign occ       = 2'(m_forward_axis_tvalid) + 2'(skid_v) + 2'(rd_pend) - 2'(pop);

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = fetch_ptr[ADDR_WIDTH-1:0];
    case (state)
      ST_IDLE: begin
        if (frames_stored != '0) begin
          rd_en   = 1'b1;
          rd_addr = rd_ptr[ADDR_WIDTH-1:0];
        end
      end
      ST_LOAD, ST_SEND: rd_en = (fetch_ptr != commit_ptr) && (occ < 2'd2) && !send_done;
      default: rd_en = 1'b0;
    endcase
  end

  // Words fetched past the frame's tlast are discarded on entry to GAP and
  // re-read from rd_ptr on the next LOAD.
  always_ff @(posedge i_data_clk or posedge i_data_rst) begin
    if (i_data_rst) begin
      state                 <= ST_IDLE;
      rd_ptr                <= '0;
      fetch_ptr             <= '0;
      head_ptr              <= '0;
      rd_pend               <= 1'b0;
      skid                  <= '0;
      skid_v                <= 1'b0;
      o_forward_pkt_valid   <= 1'b0;
      m_forward_axis_tvalid <= 1'b0;
      m_forward_axis_tdata  <= '0;
      m_forward_axis_tlast  <= 1'b0;
      m_forward_axis_tkeep  <= '0;
      o_pkt_cnt             <= '0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) fetch_ptr <= (state == ST_IDLE) ? rd_ptr + 1'b1 : fetch_ptr + 1'b1;
      case (state)
        ST_IDLE: begin
          if (frames_stored != '0) begin
            state    <= ST_LOAD;
            head_ptr <= rd_ptr;
          end
        end
        ST_LOAD, ST_SEND: begin
          if (send_done) begin
            state                 <= ST_GAP;
            rd_ptr                <= head_ptr + 1'b1;
            o_pkt_cnt             <= o_pkt_cnt + 1'b1;
            o_forward_pkt_valid   <= 1'b0;
            m_forward_axis_tvalid <= 1'b0;
            skid_v                <= 1'b0;
          end else begin
            if (state == ST_LOAD) begin
              state               <= ST_SEND;
              o_forward_pkt_valid <= 1'b1;
            end
            if (pop) head_ptr <= head_ptr + 1'b1;
            if (!m_forward_axis_tvalid || pop) begin
              if (skid_v) begin
                m_forward_axis_tvalid <= 1'b1;
                m_forward_axis_tdata  <= skid.data;
                m_forward_axis_tkeep  <= skid.keep;
                m_forward_axis_tlast  <= skid.last;
                skid_v                <= rd_pend;
                skid                  <= rd_word;
              end else if (rd_pend) begin
                m_forward_axis_tvalid <= 1'b1;
                m_forward_axis_tdata  <= rd_word.data;
                m_forward_axis_tkeep  <= rd_word.keep;
                m_forward_axis_tlast  <= rd_word.last;
              end else begin
                m_forward_axis_tvalid <= 1'b0;
              end
            end else if (rd_pend) begin
              skid   <= rd_word;
              skid_v <= 1'b1;
            end
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_forward_pkt_buffer.sv
// Directed and randomized bench for eth_forward_pkt_buffer with a beat
// scoreboard; uses a 128-word buffer so overflow cases stay short.
module tb_eth_forward_pkt_buffer;

  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, s_tready;
  logic [63:0]   s_tdata = '0;
  logic [7:0]    s_tkeep = '0;
  logic          pv, m_tvalid, m_tlast, m_tuser, m_tready;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic [CW-1:0] drop_cnt, pkt_cnt;
  logic          rdy_fixed = 1'b1, rand_rdy = 1'b0, rnd_bit = 1'b1;

  assign m_tready = rand_rdy ? rnd_bit : rdy_fixed;

  eth_forward_pkt_buffer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_data_clk            (clk),
    .i_data_rst            (rst),
    .s_axis_tvalid         (s_tvalid),
    .s_axis_tdata          (s_tdata),
    .s_axis_tlast          (s_tlast),
    .s_axis_tkeep          (s_tkeep),
    .s_axis_tuser          (s_tuser),
    .s_axis_tready         (s_tready),
    .o_forward_pkt_valid   (pv),
    .m_forward_axis_tvalid (m_tvalid),
    .m_forward_axis_tdata  (m_tdata),
    .m_forward_axis_tlast  (m_tlast),
    .m_forward_axis_tkeep  (m_tkeep),
    .m_forward_axis_tuser  (m_tuser),
    .m_forward_axis_tready (m_tready),
    .o_drop_cnt            (drop_cnt),
    .o_pkt_cnt             (pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int exp_drop = 0, exp_pkt = 0;
  int words_out = 0;
  int frame_id = 0;
  int tlast_cyc = 0, rise_cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  logic [72:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples at negedge, so a beat seen valid&ready here is taken at the next posedge.
  logic        in_frame = 1'b0, stall_prev = 1'b0, gap_pending = 1'b0, prev_pv = 1'b0;
  int          beat_cnt = 0, low_run = 100;
  logic [72:0] prev_word = '0;

  always @(negedge clk) begin
    logic [72:0] w;
    if (rst) begin
      in_frame = 1'b0; stall_prev = 1'b0; gap_pending = 1'b0; prev_pv = 1'b0;
      beat_cnt = 0; low_run = 100; words_out = 0;
    end else begin
      if (gap_pending) begin
        check("gap_low", {pv, m_tvalid}, 2'b00);
        gap_pending = 1'b0;
      end
      if (stall_prev) check("stall_hold", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, prev_word});
      if (m_tvalid) check("tvalid_without_pkt_valid", pv, 1'b1);
      if (in_frame) check("pkt_valid_mid_frame", pv, 1'b1);
      if (pv && !prev_pv) begin
        rise_cyc = cyc;
        check("min_gap", low_run >= 3, 1'b1);
        low_run = 0;
      end else if (!pv) begin
        low_run++;
      end
      prev_pv = pv;
      if (m_tvalid && m_tready) begin
        check("unexpected_beat", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("beat", {m_tlast, m_tkeep, m_tdata}, w);
        end
        if (!in_frame) first_pop_cyc = cyc;
        in_frame = !m_tlast;
        beat_cnt++;
        if (m_tlast) begin
          last_pop_cyc = cyc;
          words_out -= beat_cnt;
          beat_cnt = 0;
          gap_pending = 1'b1;
        end
      end
      stall_prev = m_tvalid && !m_tready;
      prev_word  = {m_tlast, m_tkeep, m_tdata};
    end
  end

  // Drives one frame; the last beat is left on the bus for the next caller.
  task automatic send_frame(input int len, input logic [7:0] lkeep, input logic err,
                            input logic expect_ok, input logic gaps);
    logic [63:0] d;
    frame_id++;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      while (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      d        = {16'(frame_id), 16'(i), 32'($urandom())};
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = (i == len - 1);
      s_tkeep  = s_tlast ? lkeep : 8'($urandom());
      s_tuser  = s_tlast ? err : 1'($urandom_range(0, 1));
      if (expect_ok) exp_q.push_back({s_tlast, (s_tlast ? lkeep : 8'hff), d});
      if (s_tlast) tlast_cyc = cyc;
    end
    if (expect_ok) begin
      exp_pkt++;
      words_out += len;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    idle_in();
    while ((exp_q.size() != 0 || in_frame) && n < budget) begin
      @(posedge clk); n++;
    end
    check("drain_timeout", exp_q.size() == 0 && !in_frame, 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int len;
    logic err;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {pv, m_tvalid, m_tlast, m_tkeep, m_tuser, s_tready}, {12'h000, 1'b0, 1'b1});
    check("reset_tdata", m_tdata, 64'h0);
    check("reset_counters", {drop_cnt, pkt_cnt}, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single 8-beat frame, latency and back-to-back output
    send_frame(8, 8'h0f, 1'b0, 1'b1, 1'b0);
    drain(100);
    check("latency_tlast_to_pkt_valid", rise_cyc - tlast_cyc, 3);
    check("beats_back_to_back", last_pop_cyc - first_pop_cyc, 7);
    check("pkt_cnt_single", pkt_cnt, exp_pkt);

    // Errored frame followed by a good 4-beat frame
    send_frame(5, 8'hff, 1'b1, 1'b0, 1'b0);
    send_frame(4, 8'h01, 1'b0, 1'b1, 1'b0);
    drain(100);
    check("drop_cnt_tuser", drop_cnt, exp_drop);
    check("pkt_cnt_tuser", pkt_cnt, exp_pkt);

    // Overflow while downstream stalls: second and third frames must drop
    rdy_fixed = 1'b0;
    send_frame(70, 8'h3f, 1'b0, 1'b1, 1'b0);
    send_frame(70, 8'hff, 1'b0, 1'b0, 1'b0);
    send_frame(130, 8'hff, 1'b0, 1'b0, 1'b0);
    idle_in();
    repeat (5) @(posedge clk);
    #1;
    check("drop_cnt_overflow", drop_cnt, exp_drop);
    check("stalled_frame_presented", {pv, m_tvalid}, 2'b11);
    rdy_fixed = 1'b1;
    drain(400);
    check("pkt_cnt_overflow", pkt_cnt, exp_pkt);

    // Exactly buffer-sized frame fits; one word more is dropped
    rdy_fixed = 1'b0;
    send_frame(DEPTH, 8'h80, 1'b0, 1'b1, 1'b0);
    idle_in();
    repeat (5) @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    drain(400);
    send_frame(DEPTH + 1, 8'hff, 1'b0, 1'b0, 1'b0);
    drain(400);
    check("drop_cnt_boundary", drop_cnt, exp_drop);
    check("pkt_cnt_boundary", pkt_cnt, exp_pkt);

    // Commit of frame B lands on the same edge as frame A's tlast send
    send_frame(8, 8'h07, 1'b0, 1'b1, 1'b0);
    send_frame(11, 8'h1f, 1'b0, 1'b1, 1'b0);
    send_frame(3, 8'hff, 1'b0, 1'b1, 1'b0);
    drain(200);
    check("pkt_cnt_concurrent", pkt_cnt, exp_pkt);

    // Random lengths, random input bubbles and 50% downstream ready
    rand_rdy = 1'b1;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 64);
      err = ($urandom_range(0, 4) == 0);
      n = 0;
      while (words_out + len > DEPTH && n < 5000) begin
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        n++;
      end
      check("space_wait_timeout", words_out + len <= DEPTH, 1'b1);
      send_frame(len, 8'($urandom_range(1, 255)), err, !err, 1'b1);
    end
    drain(8000);
    rand_rdy = 1'b0;
    check("drop_cnt_random", drop_cnt, exp_drop);
    check("pkt_cnt_random", pkt_cnt, exp_pkt);

    // Reset in the middle of an outgoing 16-beat frame
    send_frame(16, 8'hff, 1'b0, 1'b1, 1'b0);
    idle_in();
    n = 0;
    while (!in_frame && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reset_wait_timeout", in_frame, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_outputs", {pv, m_tvalid, m_tlast, m_tkeep, s_tready}, {11'h000, 1'b1});
    check("midreset_tdata", m_tdata, 64'h0);
    check("midreset_counters", {drop_cnt, pkt_cnt}, 32'h0);
    exp_q.delete();
    exp_drop = 0;
    exp_pkt  = 0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(6, 8'h03, 1'b0, 1'b1, 1'b0);
    drain(100);
    check("post_reset_pkt_cnt", pkt_cnt, exp_pkt);
    check("post_reset_drop_cnt", drop_cnt, exp_drop);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
